clint_bus_adapter: RTL and testbench
====================================

CLINT_BUS_ADAPTER -- requirements
Module: clint_bus_adapter

Interface
REQ-001 Parameter: XLEN, 32, data/address width.
REQ-002 Parameter: TIMEOUT_CYCLES, 15, maximum cycles spent waiting for clint_ready_i before an error response is returned (range 1..255).
REQ-003 Ports SHALL be exactly:
- clk_i  in  1  sole clock.
- rst_i  in  1  reset, asynchronous, active-high.
- p_strobe_i  in  1  one-cycle request pulse from the core device bus.
- p_we_i  in  1  1 = write, 0 = read.
- p_addr_i  in  XLEN  byte address; only bits [15:0] are decoded.
- p_be_i  in  4  write byte enables.
- p_data_i  in  XLEN  write data.
- p_data_o  out  XLEN  read data.
- p_ready_o  out  1  one-cycle completion pulse.
- p_err_o  out  1  error flag, valid with p_ready_o.
- clint_en_o  out  1  CLINT access enable.
- clint_we_o  out  1  CLINT write enable.
- clint_addr_o  out  3  CLINT word index 0..4.
- clint_data_o  out  XLEN  CLINT write data.
- clint_data_i  in  XLEN  CLINT read data.
- clint_ready_i  in  1  CLINT completion, one cycle after clint_en_o.

Function
REQ-004 The block SHALL decode offset p_addr_i[15:0] to a CLINT index: linear map 0x00->0 (mtime lo), 0x04->1 (mtime hi), 0x08->2 (mtimecmp lo), 0x0C->3 (mtimecmp hi), 0x10->4 (msip); every other offset is unmapped.
REQ-005 FSM states SHALL be IDLE, RD, RD_WAIT, WR, WR_WAIT, RESP; all outputs are registered.
REQ-006 IDLE SHALL sample p_strobe_i and latch the address, byte enables, write data and p_we_i; p_strobe_i seen in any other state SHALL be ignored.
REQ-007 Unmapped or misaligned (p_addr_i[1:0] != 0) requests: IDLE->RESP, p_err_o=1, p_data_o=0; no CLINT access occurs.
REQ-008 Read, or write with p_be_i==4'h0: IDLE->RD; RD drives clint_en_o=1, clint_we_o=0 for exactly one cycle, then RD_WAIT.
REQ-009 Write with p_be_i==4'hF: IDLE->WR; WR drives clint_en_o=1, clint_we_o=1 and clint_data_o=write data for exactly one cycle, then WR_WAIT.
REQ-010 Partial write (p_be_i not 0 and not F): performs RD/RD_WAIT, then merges byte lane i from the write data when p_be_i[i]=1 and from clint_data_i otherwise, then performs WR/WR_WAIT with the merged word (read-modify-write).
REQ-011 RD_WAIT/WR_WAIT: on clint_ready_i, capture clint_data_i (reads only) and move to the next state; p_data_o on writes SHALL be 0.
REQ-012 Timeout: an 8-bit counter clears on wait-state entry; if it reaches TIMEOUT_CYCLES without clint_ready_i, go to RESP with p_err_o=1 and p_data_o=0, skipping any pending RMW write.
REQ-013 RESP SHALL assert p_ready_o for exactly one cycle, then return to IDLE.
REQ-014 Latency from the strobe-sampling edge to p_ready_o high: mapped read or full write 3 cycles; partial write 5 cycles; unmapped 1 cycle.
REQ-015 clint_en_o and clint_we_o SHALL be 0 in every state other than RD/WR; clint_addr_o holds the latched index.

Reset
REQ-016 rst_i asserted SHALL immediately force state IDLE, the counter to 0 and all outputs to 0, asynchronously.
REQ-017 Reset asserted mid-transaction SHALL abandon the transaction; no p_ready_o is produced for it.

Configuration
REQ-018 Macro CLINT_SIFIVE_MAP_EN defined: the decode SHALL use the SiFive layout 0x0000->4, 0x4000->2, 0x4004->3, 0xBFF8->0, 0xBFFC->1, and linear offsets become unmapped. Undefined: the linear map of REQ-004 applies.

Verification
REQ-019 Read 0x08 with the CLINT returning 0x1234_5678: clint_en_o is pulsed with addr 2 and we 0; p_ready_o is high 3 cycles later with p_data_o=0x1234_5678 and p_err_o=0.
REQ-020 Write 0x10 with p_be_i=F and data 1: a single cycle with clint_en_o=clint_we_o=1, addr 4, data 1; p_ready_o follows 3 cycles after the strobe.
REQ-021 Write 0x0C with p_be_i=4'b0010 and data 0x0000_AB00 while the CLINT word is 0x1122_3344: a read is issued, then a write of 0x1122_AB44; p_ready_o arrives at 5 cycles.
REQ-022 Unmapped read 0x20, and misaligned read 0x06: p_ready_o after 1 cycle with p_err_o=1, p_data_o=0, and clint_en_o never asserted.
REQ-023 clint_ready_i held 0: p_err_o=1 with p_ready_o after TIMEOUT_CYCLES wait cycles; rst_i asserted in RD_WAIT: outputs go to 0 immediately and no p_ready_o follows.
REQ-024 With CLINT_SIFIVE_MAP_EN defined, a read of 0xBFFC reaches index 1, and a read of 0x04 returns p_err_o=1.

Source files
------------

// File: rtl/clint_bus_adapter.sv
// clint_bus_adapter: bridges single-cycle core bus strobes to a 5-word CLINT port, with read-modify-write for partial writes and a wait timeout.
// Optional feature macro CLINT_SIFIVE_MAP_EN: when defined, decode uses the SiFive CLINT layout
//   (0x0000 msip, 0x4000/0x4004 mtimecmp, 0xBFF8/0xBFFC mtime); otherwise a linear 0x00..0x10 map is used.
// Ports:
//   clk_i, rst_i (async active-high)
//   p_strobe_i/p_we_i/p_addr_i/p_be_i/p_data_i : core request; p_data_o/p_ready_o/p_err_o : response
//   clint_en_o/clint_we_o/clint_addr_o/clint_data_o : CLINT access; clint_data_i/clint_ready_i : CLINT reply
module clint_bus_adapter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            p_strobe_i,
  input  logic            p_we_i,
  input  logic [XLEN-1:0] p_addr_i,
  input  logic [3:0]      p_be_i,
  input  logic [XLEN-1:0] p_data_i,
  output logic [XLEN-1:0] p_data_o,
  output logic            p_ready_o,
  output logic            p_err_o,
  output logic            clint_en_o,
  output logic            clint_we_o,
  output logic [2:0]      clint_addr_o,
  output logic [XLEN-1:0] clint_data_o,
  input  logic [XLEN-1:0] clint_data_i,
  input  logic            clint_ready_i
);
  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, WR_WAIT, RESP} state_t;
  state_t          state_q;
  logic [7:0]      cnt_q, cnt_d;
  logic            we_q, rmw_q, timeout;
  logic [3:0]      be_q;
  logic [XLEN-1:0] wdata_q, mask, merged;
  logic [15:0]     off;
  logic            hit;
  logic [2:0]      idx;
  logic            unused_addr;
  assign off         = p_addr_i[15:0];
  assign unused_addr = ^p_addr_i[XLEN-1:16];
`ifdef CLINT_SIFIVE_MAP_EN
  assign hit = off inside {16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC};
  assign idx = off == 16'h0000 ? 3'd4 :
               off == 16'h4000 ? 3'd2 :
               off == 16'h4004 ? 3'd3 :
               off == 16'hBFF8 ? 3'd0 : 3'd1;
`else
  assign hit = off[15:5] == 11'd0 && off[1:0] == 2'd0 && off[4:2] <= 3'd4;
  assign idx = off[4:2];
`endif
  assign cnt_d   = cnt_q + 8'd1;
  assign timeout = cnt_d == 8'(TIMEOUT_CYCLES);
  // lanes above the 4 byte-enable lanes always come from the write data
  always_comb begin
    mask = '1;
    for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{be_q[i]}};
  end
  assign merged = (wdata_q & mask) | (clint_data_i & ~mask);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      rmw_q        <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      p_data_o     <= '0;
      p_ready_o    <= 1'b0;
      p_err_o      <= 1'b0;
      clint_en_o   <= 1'b0;
      clint_we_o   <= 1'b0;
      clint_addr_o <= '0;
      clint_data_o <= '0;
    end else begin
      case (state_q)
        IDLE: if (p_strobe_i) begin
          we_q         <= p_we_i;
          be_q         <= p_be_i;
          wdata_q      <= p_data_i;
          rmw_q        <= p_we_i && p_be_i != 4'h0 && p_be_i != 4'hF;
          clint_addr_o <= hit ? idx : 3'd0;
          if (!hit) begin
            state_q   <= RESP;
            p_ready_o <= 1'b1;
            p_err_o   <= 1'b1;
            p_data_o  <= '0;
          end else if (p_we_i && p_be_i == 4'hF) begin
            state_q      <= WR;
            clint_en_o   <= 1'b1;
            clint_we_o   <= 1'b1;
            clint_data_o <= p_data_i;
          end else begin
            state_q    <= RD;
            clint_en_o <= 1'b1;
          end
        end
        RD: begin
          state_q    <= RD_WAIT;
          clint_en_o <= 1'b0;
          cnt_q      <= '0;
        end
        WR: begin
          state_q    <= WR_WAIT;
          clint_en_o <= 1'b0;
          clint_we_o <= 1'b0;
          cnt_q      <= '0;
        end
        RD_WAIT: if (clint_ready_i && rmw_q) begin
          state_q      <= WR;
          clint_en_o   <= 1'b1;
          clint_we_o   <= 1'b1;
          clint_data_o <= merged;
        end else if (clint_ready_i || timeout) begin
          state_q   <= RESP;
          p_ready_o <= 1'b1;
          p_err_o   <= !clint_ready_i;
          p_data_o  <= clint_ready_i && !we_q ? clint_data_i : '0;
        end else cnt_q <= cnt_d;
        WR_WAIT: if (clint_ready_i || timeout) begin
          state_q   <= RESP;
          p_ready_o <= 1'b1;
          p_err_o   <= !clint_ready_i;
          p_data_o  <= '0;
        end else cnt_q <= cnt_d;
        RESP: begin
          state_q   <= IDLE;
          p_ready_o <= 1'b0;
          p_err_o   <= 1'b0;
          p_data_o  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clint_bus_adapter.sv
// tb_clint_bus_adapter: directed vector table plus timeout/reset/busy-strobe sequences for clint_bus_adapter.
module tb_clint_bus_adapter;
  localparam int TO = 15;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        p_strobe_i = 1'b0, p_we_i = 1'b0;
  logic [31:0] p_addr_i = '0, p_data_i = '0, p_data_o;
  logic [3:0]  p_be_i = '0;
  logic        p_ready_o, p_err_o, clint_en_o, clint_we_o;
  logic [2:0]  clint_addr_o;
  logic [31:0] clint_data_o, clint_data_i, mem = '0;
  logic        clint_ready_i = 1'b0, resp_en = 1'b1;
  int          n_chk = 0, n_fail = 0;
  int          lat, nen, nwr, np;
  logic        err;
  logic [31:0] rd, lwd;
  logic [2:0]  idx;

  clint_bus_adapter #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .p_strobe_i(p_strobe_i), .p_we_i(p_we_i),
    .p_addr_i(p_addr_i), .p_be_i(p_be_i), .p_data_i(p_data_i), .p_data_o(p_data_o),
    .p_ready_o(p_ready_o), .p_err_o(p_err_o), .clint_en_o(clint_en_o), .clint_we_o(clint_we_o),
    .clint_addr_o(clint_addr_o), .clint_data_o(clint_data_o), .clint_data_i(clint_data_i),
    .clint_ready_i(clint_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // CLINT model: one-word store, replies one cycle after an enable
  assign clint_data_i = mem;
  always @(posedge clk_i) clint_ready_i <= clint_en_o & resp_en;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd, mem;
    int          lat;
    logic        err;
    logic [31:0] rd;
    int          nen, nwr;
    logic [2:0]  idx;
    logic [31:0] lwd;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // latency = index of the first clock edge (strobe-sampling edge is 0) at which p_ready_o is high
  task automatic run(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                     input int hold, input int win);
    @(negedge clk_i);
    p_strobe_i = 1'b1; p_we_i = we; p_addr_i = a; p_be_i = be; p_data_i = wd;
    lat = 0; err = 1'bx; rd = 'x; nen = 0; nwr = 0; np = 0; idx = 'x; lwd = 'x;
    for (int c = 0; c < win; c++) begin
      @(posedge clk_i); #1;
      if (c + 1 >= hold) p_strobe_i = 1'b0;
      if (clint_en_o) begin
        nen++;
        idx = clint_addr_o;
        if (clint_we_o) begin nwr++; lwd = clint_data_o; end
      end
      if (p_ready_o) begin
        np++;
        if (np == 1) begin lat = c + 1; err = p_err_o; rd = p_data_o; end
      end
    end
  endtask

  initial begin
`ifdef CLINT_SIFIVE_MAP_EN
    v.push_back('{0, 32'hBFFC, 4'h0, 32'h0, 32'h0000_00C3, 3, 0, 32'h0000_00C3, 1, 0, 3'd1, 32'h0});
    v.push_back('{0, 32'h0004, 4'h0, 32'h0, 32'h1111_1111, 1, 1, 32'h0, 0, 0, 3'd0, 32'h0});
    v.push_back('{1, 32'h4004, 4'hF, 32'h5, 32'h0, 3, 0, 32'h0, 1, 1, 3'd3, 32'h5});
    v.push_back('{0, 32'h0000, 4'h0, 32'h0, 32'h0000_0001, 3, 0, 32'h0000_0001, 1, 0, 3'd4, 32'h0});
    v.push_back('{0, 32'hBFF8, 4'h0, 32'h0, 32'hCAFE_0000, 3, 0, 32'hCAFE_0000, 1, 0, 3'd0, 32'h0});
    v.push_back('{0, 32'h0008, 4'h0, 32'h0, 32'h2222_2222, 1, 1, 32'h0, 0, 0, 3'd0, 32'h0});
    v.push_back('{1, 32'h4000, 4'b0010, 32'h0000_AB00, 32'h1122_3344, 5, 0, 32'h0, 2, 1, 3'd2, 32'h1122_AB44});
`else
    v.push_back('{0, 32'h08, 4'h0, 32'h0, 32'h1234_5678, 3, 0, 32'h1234_5678, 1, 0, 3'd2, 32'h0});
    v.push_back('{1, 32'h10, 4'hF, 32'h1, 32'h0, 3, 0, 32'h0, 1, 1, 3'd4, 32'h1});
    v.push_back('{1, 32'h0C, 4'b0010, 32'h0000_AB00, 32'h1122_3344, 5, 0, 32'h0, 2, 1, 3'd3, 32'h1122_AB44});
    v.push_back('{0, 32'h20, 4'h0, 32'h0, 32'h5555_5555, 1, 1, 32'h0, 0, 0, 3'd0, 32'h0});
    v.push_back('{0, 32'h06, 4'h0, 32'h0, 32'h5555_5555, 1, 1, 32'h0, 0, 0, 3'd0, 32'h0});
    v.push_back('{0, 32'h00, 4'h0, 32'h0, 32'hDEAD_BEEF, 3, 0, 32'hDEAD_BEEF, 1, 0, 3'd0, 32'h0});
    v.push_back('{0, 32'h04, 4'h0, 32'h0, 32'hA5A5_0001, 3, 0, 32'hA5A5_0001, 1, 0, 3'd1, 32'h0});
    v.push_back('{1, 32'h00, 4'h0, 32'hFFFF_FFFF, 32'h7777_7777, 3, 0, 32'h0, 1, 0, 3'd0, 32'h0});
    v.push_back('{1, 32'h08, 4'b1001, 32'hAABB_CCDD, 32'h1122_3344, 5, 0, 32'h0, 2, 1, 3'd2, 32'hAA22_33DD});
    v.push_back('{0, 32'h14, 4'h0, 32'h0, 32'h0, 1, 1, 32'h0, 0, 0, 3'd0, 32'h0});
    v.push_back('{0, 32'h0001_0004, 4'h0, 32'h0, 32'h0000_0077, 3, 0, 32'h0000_0077, 1, 0, 3'd1, 32'h0});
    v.push_back('{0, 32'h8000, 4'h0, 32'h0, 32'h0, 1, 1, 32'h0, 0, 0, 3'd0, 32'h0});
`endif
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", {31'd0, p_ready_o}, 0);
    chk("rst_err", {31'd0, p_err_o}, 0);
    chk("rst_data", p_data_o, 0);
    chk("rst_en", {30'd0, clint_en_o, clint_we_o}, 0);
    @(negedge clk_i) rst_i = 1'b0;

    foreach (v[i]) begin
      mem = v[i].mem;
      run(v[i].we, v[i].a, v[i].be, v[i].wd, 1, 25);
      chk($sformatf("v%0d_lat", i), lat, v[i].lat);
      chk($sformatf("v%0d_pulses", i), np, 1);
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, v[i].err});
      chk($sformatf("v%0d_data", i), rd, v[i].rd);
      chk($sformatf("v%0d_nen", i), nen, v[i].nen);
      chk($sformatf("v%0d_nwr", i), nwr, v[i].nwr);
      if (v[i].nen > 0) chk($sformatf("v%0d_idx", i), {29'd0, idx}, {29'd0, v[i].idx});
      if (v[i].nwr > 0) chk($sformatf("v%0d_wdata", i), lwd, v[i].lwd);
    end

    // strobe held high while busy must not start a second transaction
    mem = 32'h0BAD_F00D;
    run(0, 32'h0, 4'h0, 32'h0, 3, 25);
    chk("busy_pulses", np, 1);
    chk("busy_nen", nen, 1);
    chk("busy_lat", lat, 3);

    // CLINT never answers: error after TO wait cycles; partial write skips its write phase
    resp_en = 1'b0;
    run(0, 32'h0, 4'h0, 32'h0, 1, 40);
    chk("to_rd_lat", lat, TO + 2);
    chk("to_rd_err", {31'd0, err}, 1);
    chk("to_rd_data", rd, 0);
    chk("to_rd_nen", nen, 1);
    run(1, 32'h0C, 4'b0010, 32'h0000_AB00, 1, 40);
    chk("to_rmw_lat", lat, TO + 2);
    chk("to_rmw_err", {31'd0, err}, 1);
    chk("to_rmw_nwr", nwr, 0);

    // reset while in RD_WAIT abandons the transaction
    @(negedge clk_i);
    p_strobe_i = 1'b1; p_we_i = 1'b0; p_addr_i = 32'h08; p_be_i = 4'h0;
    @(posedge clk_i); #1 p_strobe_i = 1'b0;
    @(posedge clk_i); #2 rst_i = 1'b1;
    #1;
    chk("arst_ready", {31'd0, p_ready_o}, 0);
    chk("arst_addr", {29'd0, clint_addr_o}, 0);
    chk("arst_en", {30'd0, clint_en_o, clint_we_o}, 0);
    chk("arst_data", p_data_o | clint_data_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0; resp_en = 1'b1;
    np = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk_i); #1;
      if (p_ready_o) np++;
    end
    chk("arst_no_ready", np, 0);
    mem = 32'h0000_0042;
    run(0, 32'h0, 4'h0, 32'h0, 1, 25);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_data", rd, 32'h0000_0042);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
